// File: rtl/msg_resp.sv
// OPB read-response framer: waits for the read ack (or times out) and streams the
// response frame into the TX FIFO. Define MSG_RESP_CHECKSUM_EN to insert an XOR checksum byte.
module msg_resp #(
    parameter logic [15:0] ACK_TIMEOUT = 16'd1000
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic        RD_REQ,
    input  logic [31:0] RD_ADDR,
    input  logic [31:0] OPB_DI,
    input  logic        OPB_RD_ACK,
    output logic        TX_FIFO_WR,
    output logic [7:0]  TX_FIFO_DATA,
    input  logic        TX_FIFO_FULL,
    output logic        BUSY,
    output logic        RD_DROP,
    output logic        RESP_DONE
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, SEND, DONE} state_t;

`ifdef MSG_RESP_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd10;
`else
    localparam logic [3:0] LAST_IDX = 4'd9;
`endif

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  hdr_q, hdr_d;
    logic        tx_wr;
    logic [7:0]  byte_sel;

`ifdef MSG_RESP_CHECKSUM_EN
    logic [7:0] chk;
    assign chk = addr_q[31:24] ^ addr_q[23:16] ^ addr_q[15:8] ^ addr_q[7:0]
               ^ data_q[31:24] ^ data_q[23:16] ^ data_q[15:8] ^ data_q[7:0];
`endif

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 16'd0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            hdr_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            hdr_q   <= hdr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        hdr_d   = hdr_q;
        case (state_q)
            IDLE: begin
                if (RD_REQ) begin
                    addr_d  = RD_ADDR;
                    cnt_d   = 16'd0;
                    idx_d   = 4'd0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                cnt_d = (cnt_q == ACK_TIMEOUT) ? cnt_q : cnt_q + 16'd1;
                // A real ack always beats an expiring timeout in the same cycle
                if (OPB_RD_ACK) begin
                    data_d  = OPB_DI;
                    hdr_d   = 8'h5C;
                    state_d = SEND;
                end else if (cnt_q == ACK_TIMEOUT - 16'd1) begin
                    data_d  = 32'hDEADBEEF;
                    hdr_d   = 8'h5D;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_wr) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 4'd0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_wr     = (state_q == SEND) && !TX_FIFO_FULL;
        BUSY      = (state_q != IDLE);
        RESP_DONE = (state_q == DONE);
        RD_DROP   = RD_REQ && (state_q != IDLE);
        byte_sel  = 8'h00;
        case (idx_q)
            4'd0: byte_sel = hdr_q;
            4'd1: byte_sel = addr_q[31:24];
            4'd2: byte_sel = addr_q[23:16];
            4'd3: byte_sel = addr_q[15:8];
            4'd4: byte_sel = addr_q[7:0];
            4'd5: byte_sel = data_q[31:24];
            4'd6: byte_sel = data_q[23:16];
            4'd7: byte_sel = data_q[15:8];
            4'd8: byte_sel = data_q[7:0];
`ifdef MSG_RESP_CHECKSUM_EN
            4'd9:  byte_sel = chk;
            4'd10: byte_sel = ~hdr_q;
`else
            4'd9: byte_sel = ~hdr_q;
`endif
            default: byte_sel = 8'h00;
        endcase
    end

    assign TX_FIFO_WR   = tx_wr;
    assign TX_FIFO_DATA = byte_sel;

endmodule
